// File: rtl/decode_pkg.sv
// Shared encodings and the decoded bundle type for the ARM-subset decode stage.
package decode_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a3;
        logic        is_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src_imm;
        logic [1:0]  alu_ctl;
        logic        set_flags;
        logic        branch;
        logic [31:0] ext_imm;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_stage_cond_check.sv
// Combinational ARM condition-code evaluation against {N,Z,C,V}.
module cond_check
    import decode_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// ARM DP/LDR-STR/B decode stage with NZCV register and a 1-entry output register.
// Optional macro DECODE_BL_EN: op=10 with L=1 writes the link register (BL).
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] instr,
    output logic              outValid,
    input  logic              outReady,
    input  logic              flush,
    input  logic              flagWrite,
    input  logic [3:0]        aluFlags,
    output logic [ADDR_W-1:0] A1,
    output logic [ADDR_W-1:0] A2,
    output logic [ADDR_W-1:0] A3,
    output logic              isWrite,
    output logic              memWrite,
    output logic              memToReg,
    output logic              aluSrcImm,
    output logic [1:0]        aluControl,
    output logic              setFlags,
    output logic              branch,
    output logic [DATA_W-1:0] extImm,
    output logic              illegal
);
    logic        out_valid_q, out_valid_d;
    logic [3:0]  nzcv_q, nzcv_d, nzcv_eff;
    dec_bundle_t bundle_q, bundle_d, dec;
    logic        cond_pass, capture, ill;

    assign inReady  = !out_valid_q || outReady;
    assign capture  = inValid && inReady && !flush;
    // Flags written this cycle are visible to the instruction being captured.
    assign nzcv_eff = flagWrite ? aluFlags : nzcv_q;

    cond_check u_cond (
        .cond (instr[31:28]),
        .nzcv (nzcv_eff),
        .pass (cond_pass)
    );

    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (instr[27:26])
            OP_DP: begin
                dec.a1          = instr[19:16];
                dec.a2          = instr[3:0];
                dec.a3          = instr[15:12];
                dec.is_write    = 1'b1;
                dec.alu_src_imm = instr[25];
                dec.set_flags   = instr[20];
                case (instr[24:21])
                    CMD_ADD: dec.alu_ctl = ALU_ADD;
                    CMD_SUB: dec.alu_ctl = ALU_SUB;
                    CMD_AND: dec.alu_ctl = ALU_AND;
                    CMD_ORR: dec.alu_ctl = ALU_ORR;
                    default: ill = 1'b1;
                endcase
                if (instr[25]) begin
                    dec.ext_imm = {24'b0, instr[7:0]};
                    if (instr[11:8] != 4'b0) ill = 1'b1;
                end else if (instr[11:4] != 8'b0) begin
                    ill = 1'b1;
                end
            end
            OP_MEM: begin
                dec.a1          = instr[19:16];
                dec.a2          = instr[15:12];
                dec.a3          = instr[15:12];
                dec.alu_src_imm = 1'b1;
                dec.ext_imm     = {20'b0, instr[11:0]};
                dec.alu_ctl     = instr[23] ? ALU_ADD : ALU_SUB;
                if (instr[20]) begin
                    dec.is_write   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end else begin
                    dec.mem_write  = 1'b1;
                end
                // Register-offset addressing is outside the supported subset.
                if (instr[25]) ill = 1'b1;
            end
            OP_BR: begin
                dec.a1          = REG_PC;
                dec.alu_src_imm = 1'b1;
                dec.alu_ctl     = ALU_ADD;
                dec.ext_imm     = {{6{instr[23]}}, instr[23:0], 2'b00};
                dec.branch      = 1'b1;
`ifdef DECODE_BL_EN
                if (instr[24]) begin
                    dec.is_write = 1'b1;
                    dec.a3       = REG_LR;
                end
`endif
            end
            default: ill = 1'b1;
        endcase
        if (instr[31:28] == COND_NV) ill = 1'b1;

        dec.illegal = ill;
        if (ill) begin
            dec.is_write   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.set_flags  = 1'b0;
            dec.branch     = 1'b0;
        end else if (!cond_pass) begin
            // Failed condition retires as a NOP: no architectural side effects.
            dec.is_write   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.set_flags  = 1'b0;
            dec.branch     = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        nzcv_d      = flagWrite ? aluFlags : nzcv_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            nzcv_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            nzcv_q      <= nzcv_d;
        end
    end

    assign outValid   = out_valid_q;
    assign A1         = bundle_q.a1;
    assign A2         = bundle_q.a2;
    assign A3         = bundle_q.a3;
    assign isWrite    = bundle_q.is_write;
    assign memWrite   = bundle_q.mem_write;
    assign memToReg   = bundle_q.mem_to_reg;
    assign aluSrcImm  = bundle_q.alu_src_imm;
    assign aluControl = bundle_q.alu_ctl;
    assign setFlags   = bundle_q.set_flags;
    assign branch     = bundle_q.branch;
    assign extImm     = bundle_q.ext_imm;
    assign illegal    = bundle_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected bundles, monitor checks on handshake.
module tb_decode_stage;
    logic        clock = 1'b0, reset = 1'b1;
    logic        inValid = 1'b0, outReady = 1'b1, flush = 1'b0, flagWrite = 1'b0;
    logic [3:0]  aluFlags = 4'h0;
    logic [31:0] instr = 32'h0;
    logic        inReady, outValid, isWrite, memWrite, memToReg, aluSrcImm, setFlags, branch, illegal;
    logic [3:0]  A1, A2, A3;
    logic [1:0]  aluControl;
    logic [31:0] extImm;

    decode_stage #(.DATA_W(32), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .instr(instr),
        .outValid(outValid), .outReady(outReady), .flush(flush), .flagWrite(flagWrite),
        .aluFlags(aluFlags), .A1(A1), .A2(A2), .A3(A3), .isWrite(isWrite), .memWrite(memWrite),
        .memToReg(memToReg), .aluSrcImm(aluSrcImm), .aluControl(aluControl), .setFlags(setFlags),
        .branch(branch), .extImm(extImm), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  a1, a2, a3;
        logic        w, mw, m2r, ai;
        logic [1:0]  ctl;
        logic        sf, br;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    n_pass = 0, n_total = 0;

    // en = {isWrite, memWrite, memToReg, aluSrcImm, setFlags, branch}
    function automatic exp_t mk(logic [3:0] a1, logic [3:0] a2, logic [3:0] a3, logic [5:0] en,
                                logic [1:0] ctl, logic [31:0] imm, logic ill);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.a3 = a3;
        {e.w, e.mw, e.m2r, e.ai, e.sf, e.br} = en;
        e.ctl = ctl; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t act();
        return {A1, A2, A3, isWrite, memWrite, memToReg, aluSrcImm, aluControl, setFlags, branch, extImm, illegal};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            tq.delete();
        end else if (outValid && (outReady || flush)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(act()), 64'h0);
            end else begin
                exp_t  e;
                string nm;
                e  = q.pop_front();
                nm = tq.pop_front();
                if (!flush) chk(nm, 64'(act()), 64'(e));
            end
        end
    end

    task automatic send(input string name, input logic [31:0] ins, input exp_t e,
                        input logic fw, input logic [3:0] fl);
        int waited = 0;
        inValid = 1'b1; instr = ins; flagWrite = fw; aluFlags = fl;
        while (!inReady && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!inReady) begin
            n_total++;
            $display("FAIL %s_timeout: inReady stayed 0 expected 1", name);
        end else begin
            q.push_back(e);
            tq.push_back(name);
            @(posedge clock); #1;
        end
        inValid = 1'b0; flagWrite = 1'b0;
    endtask

    initial begin
        exp_t e_b, e_bl;
        e_b = mk(4'd15, 4'd0, 4'd0, 6'b000101, 2'b00, 32'hFFFFFFF8, 1'b0);
`ifdef DECODE_BL_EN
        e_bl = mk(4'd15, 4'd0, 4'd14, 6'b100101, 2'b00, 32'hFFFFFFF8, 1'b0);
`else
        e_bl = e_b;
`endif
        repeat (2) @(posedge clock);
        #1;
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_bundle", 64'(act()), 64'd0);
        chk("rst_inReady", 64'(inReady), 64'd1);
        reset = 1'b0;

        send("add",   32'hE0814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 0, 4'h0);
        send("ldr",   32'hE5953008, mk(5, 3, 3, 6'b101100, 2'b00, 32'h8, 0), 0, 4'h0);
        send("str",   32'hE5053004, mk(5, 3, 3, 6'b010100, 2'b01, 32'h4, 0), 0, 4'h0);
        send("subs",  32'hE2510010, mk(1, 0, 0, 6'b100110, 2'b01, 32'h10, 0), 0, 4'h0);
        send("addeq_byp", 32'h00814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 1, 4'b0100);
        send("addne_byp", 32'h10814002, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 0), 1, 4'b0100);
        send("addeq_st",  32'h00814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 0, 4'h0);
        send("orr",   32'hE1832004, mk(3, 4, 2, 6'b100000, 2'b11, 32'h0, 0), 0, 4'h0);
        send("and",   32'hE0065007, mk(6, 7, 5, 6'b100000, 2'b10, 32'h0, 0), 0, 4'h0);
        send("addcs_byp", 32'h20814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 1, 4'b0010);
        send("addhi_st",  32'h80814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 0, 4'h0);
        send("addls_st",  32'h90814002, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 0), 0, 4'h0);
        send("addlt_byp", 32'hB0814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 1, 4'b1000);
        send("addge_st",  32'hA0814002, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 0), 0, 4'h0);
        send("beq_fail",  32'h0AFFFFFE, mk(15, 0, 0, 6'b000100, 2'b00, 32'hFFFFFFF8, 0), 0, 4'h0);
        send("b",     32'hEAFFFFFE, e_b, 0, 4'h0);
        send("bl",    32'hEBFFFFFE, e_bl, 0, 4'h0);
        send("ill_op11",  32'hEC000000, mk(0, 0, 0, 6'b000000, 2'b00, 32'h0, 1), 0, 4'h0);
        send("ill_nv",    32'hF0814002, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 1), 0, 4'h0);
        send("ill_shift", 32'hE0814102, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 1), 0, 4'h0);
        send("ill_cmd",   32'hE1A01002, mk(0, 2, 1, 6'b000000, 2'b00, 32'h0, 1), 0, 4'h0);
        repeat (2) @(posedge clock);
        #1;

        // Flags update with no instruction in flight, then a stored-flag EQ.
        flagWrite = 1'b1; aluFlags = 4'b0100;
        @(posedge clock); #1;
        flagWrite = 1'b0;
        send("addeq_idlefw", 32'h00814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 0, 4'h0);
        repeat (2) @(posedge clock);
        #1;

        // Stall: held bundle frozen and upstream blocked, then flushed away.
        outReady = 1'b0;
        send("orr_stall", 32'hE1832004, mk(3, 4, 2, 6'b100000, 2'b11, 32'h0, 0), 0, 4'h0);
        inValid = 1'b1; instr = 32'hE0814002;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("stall_inReady", 64'(inReady), 64'd0);
            chk("stall_outValid", 64'(outValid), 64'd1);
            chk("stall_held", 64'(act()), 64'(mk(3, 4, 2, 6'b100000, 2'b11, 32'h0, 0)));
        end
        inValid = 1'b0; flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_outValid", 64'(outValid), 64'd0);

        // Flush beats a simultaneous capture.
        outReady = 1'b1; inValid = 1'b1; instr = 32'hE0814002; flush = 1'b1;
        @(posedge clock); #1;
        inValid = 1'b0; flush = 1'b0;
        chk("flush_beats_capture", 64'(outValid), 64'd0);

        // Reset during a stall clears the bundle and NZCV (Z was set above).
        outReady = 1'b0;
        send("add_prerst", 32'hE0814002, mk(1, 2, 4, 6'b100000, 2'b00, 32'h0, 0), 0, 4'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_outValid", 64'(outValid), 64'd0);
        chk("midrst_bundle", 64'(act()), 64'd0);
        reset = 1'b0; outReady = 1'b1;
        send("addeq_postrst", 32'h00814002, mk(1, 2, 4, 6'b000000, 2'b00, 32'h0, 0), 0, 4'h0);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
